cla_seq_adder: RTL and testbench

CLA_SEQ_ADDER -- requirements
Module: cla_seq_adder

---
 rtl/cla_seq_adder.sv | 120 ++++++++++++
 tb/tb_cla_seq_adder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cla_seq_adder.sv
// Sequential WIDTH-bit adder built from a single 4-bit carry-lookahead slice, one nibble per cycle.
// Optional subtract mode (a - b as a + ~b + 1) is enabled by defining CLA_SEQ_SUB_EN.
module cla_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef CLA_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);

  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, c_out_q, c_out_d;

  logic [3:0] nib_a, nib_b, g, p, c, slice_sum;
  logic       slice_cout;

  // The one and only adder: a 4-bit lookahead slice fed from the current nibble.
  always_comb begin
    nib_a = a_q[{cnt_q, 2'b00} +: 4];
    nib_b = b_q[{cnt_q, 2'b00} +: 4];
    g     = nib_a & nib_b;
    p     = nib_a ^ nib_b;
    c[0]  = carry_q;
    c[1]  = g[0] | (p[0] & carry_q);
    c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
    c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry_q);
    slice_cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & carry_q);
    slice_sum  = p ^ c;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          cnt_d   = '0;
          state_d = ST_RUN;
`ifdef CLA_SEQ_SUB_EN
          if (sub) begin
            b_d     = ~b;
            carry_d = 1'b1;
          end
`endif
        end
      end
      ST_RUN: begin
        sum_d[{cnt_q, 2'b00} +: 4] = slice_sum;
        carry_d = slice_cout;
        if (cnt_q == LAST) begin
          c_out_d = slice_cout;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Scoreboard bench for cla_seq_adder (WIDTH=16): directed vectors, stall, reset-abort,
// back-to-back random traffic, and subtract vectors when CLA_SEQ_SUB_EN is defined.
module tb_cla_seq_adder;
  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
`ifdef CLA_SEQ_SUB_EN
  logic         sub_i = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         c_out;
  logic         busy;

  logic [W:0]   exp_q[$];
  int           acc_q[$];
  int           cyc = 0;
  int           n_vec = 0;
  int           n_err = 0;
  logic         b2b_chk = 1'b0;
  logic         b2b_seen = 1'b0;
  logic         ov_prev = 1'b0;
  int           last_rise = 0;

  cla_seq_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in),
`ifdef CLA_SEQ_SUB_EN
    .sub(sub_i),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .c_out(c_out), .busy(busy)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // driver: present operands after a posedge, hold until accepted, record expectation
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                      input logic ts, input logic [W:0] texp);
    int w;
    @(posedge clk); #1;
    a = ta; b = tb_v; c_in = tc; in_valid = 1'b1;
`ifdef CLA_SEQ_SUB_EN
    sub_i = ts;
`else
    if (ts) check("sub_not_built", 32'(ts), 32'd0);
`endif
    w = 0;
    while (!in_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    exp_q.push_back(texp);
    acc_q.push_back(cyc);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // monitor: latency, back-to-back period, and result compare on each handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !ov_prev) begin
        if (acc_q.size() != 0) check("latency", 32'(cyc - acc_q.pop_front()), 32'(N));
        if (b2b_chk) begin
          if (b2b_seen) check("b2b_period", 32'(cyc - last_rise), 32'(N + 2));
          b2b_seen <= 1'b1;
        end else begin
          b2b_seen <= 1'b0;
        end
        last_rise <= cyc;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          check("sum", 32'(sum), 32'(e[W-1:0]));
          check("c_out", 32'(c_out), 32'(e[W]));
        end
      end
    end
    ov_prev <= out_valid;
  end

  typedef struct { logic [W-1:0] va; logic [W-1:0] vb; logic vc; logic [W:0] ve; } vec_t;
  vec_t dir_v[5];

  initial begin
    dir_v[0] = '{16'h1234, 16'h4321, 1'b0, {1'b0, 16'h5555}};
    dir_v[1] = '{16'hFFFF, 16'h0001, 1'b0, {1'b1, 16'h0000}};
    dir_v[2] = '{16'hFFFF, 16'h0000, 1'b1, {1'b1, 16'h0000}};
    dir_v[3] = '{16'h8000, 16'h8000, 1'b0, {1'b1, 16'h0000}};
    dir_v[4] = '{16'h0F0F, 16'h00F1, 1'b0, {1'b0, 16'h1000}};

    // reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_c_out", 32'(c_out), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // directed vectors
    foreach (dir_v[i]) send(dir_v[i].va, dir_v[i].vb, dir_v[i].vc, 1'b0, dir_v[i].ve);
    @(posedge clk); #1 in_valid = 1'b0;
    drain();

    // stall in DONE with a competing request
    out_ready = 1'b0;
    send(16'h1234, 16'h1111, 1'b0, 1'b0, {1'b0, 16'h2345});
    for (int w = 0; w < 20 && !out_valid; w++) @(negedge clk);
    check("stall_reached_done", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    a = 16'hAAAA; b = 16'h5555; c_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_sum", 32'(sum), 32'h2345);
      check("stall_c_out", 32'(c_out), 32'd0);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_busy", 32'(busy), 32'd0);
    check("release_sum_kept", 32'(sum), 32'h2345);
    check("release_queue", 32'(exp_q.size()), 32'd0);

    // reset during RUN step k=2
    send(16'h1234, 16'h4321, 1'b0, 1'b0, {1'b0, 16'h5555});
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, {1'b0, 16'h0100});
    @(posedge clk); #1 in_valid = 1'b0;
    drain();

`ifdef CLA_SEQ_SUB_EN
    send(16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 16'hFFFE});
    send(16'h0007, 16'h0005, 1'b1, 1'b1, {1'b1, 16'h0002});
    @(posedge clk); #1 in_valid = 1'b0; sub_i = 1'b0;
    drain();
`endif

    // back-to-back random traffic against a+b+c_in
    b2b_chk = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra, rb;
      logic rc;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      send(ra, rb, rc, 1'b0, {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc});
    end
    in_valid = 1'b0;
    drain();
    b2b_chk = 1'b0;

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
